// File: rtl/lc4_div_pkg.sv
// Shared constants and state encoding for the LC4 iterative divider.
package lc4_div_pkg;

  localparam int W     = 16;  // operand width, fixed by cla16
  localparam int CNT_W = 5;   // iteration counter width, holds 0..W
  localparam int ITERS = 16;  // quotient bits produced, one per BUSY cycle

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lc4_divider_iter_if.sv
// Operand/result handshake bundle between issue, divider and writeback.
interface lc4_divider_iter_if;
  import lc4_div_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  // Issue/writeback side: presents operands and takes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );

endinterface

// File: rtl/lc4_divider_iter_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with lookahead between
// groups and a short ripple inside each group. Sum only; callers derive
// any carry they need from the sum bits.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, inter-group lookahead, then per-bit carries.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would infer a latch.
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int k = 0; k < 3; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
    grp_c[0] = cin;
    for (int k = 0; k < 3; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/lc4_divider_iter.sv
// Multi-cycle 16-bit unsigned restoring divider for LC4 DIV/MOD.
// One quotient bit per BUSY cycle, MSB first. The dividend is shifted out
// of the quotient register as quotient bits are shifted in.
module lc4_divider_iter
  import lc4_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  lc4_divider_iter_if.slave  bus
);

  state_t           state;
  logic [W-1:0]     q_r;     // dividend on load, quotient when DONE
  logic [W-1:0]     rem_r;   // partial remainder
  logic [W-1:0]     div_r;   // latched divisor
  logic [CNT_W-1:0] cnt;     // steps completed

  logic             accept;
  logic [W-1:0]     s;
  logic [W-1:0]     nb;
  logic [W-1:0]     trial;
  logic             c15;
  logic             cout16;
  logic             borrow_free;

  // A new operation may start from IDLE, or from DONE in the same cycle the
  // current result is taken.
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = q_r;
  assign bus.remainder = rem_r;

  // Trial subtract: s - divisor as s + ~divisor + 1.
  assign s  = {rem_r[W-2:0], q_r[W-1]};
  assign nb = ~div_r;

  cla16 u_cla16 (
    .a   (s),
    .b   (nb),
    .cin (1'b1),
    .sum (trial)
  );

  // Recover the carry out of bit 15 from the sum; rem_r[15] stands in for
  // the 17th bit of the shifted remainder, which always exceeds the divisor.
  assign c15         = trial[W-1] ^ s[W-1] ^ nb[W-1];
  assign cout16      = (s[W-1] & nb[W-1]) | ((s[W-1] ^ nb[W-1]) & c15);
  assign borrow_free = rem_r[W-1] | cout16;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
      q_r   <= '0;
      rem_r <= '0;
      div_r <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        q_r   <= '0;
        rem_r <= '0;
        state <= DONE;
      end else begin
        q_r   <= bus.dividend;
        div_r <= bus.divisor;
        rem_r <= '0;
        cnt   <= '0;
        state <= BUSY;
      end
    end else begin
      case (state)
        BUSY: begin
          q_r   <= {q_r[W-2:0], borrow_free};
          rem_r <= borrow_free ? trial : s;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(ITERS - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Directed self-checking bench for lc4_divider_iter.
module tb_lc4_divider_iter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lc4_divider_iter_if bus ();

  lc4_divider_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present operands until accepted; returns one ns after the accept edge.
  task automatic do_accept(input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", guard < 100, 1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'hDEAD;
    bus.divisor  = 16'hBEEF;
  endtask

  // Cycles from the accept cycle until out_valid is first seen (1 = next cycle).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input int elat);
    int lat;
    bus.out_ready = 1'b1;
    do_accept(a, b);
    wait_result(lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   lat;
    logic seen;
    logic [15:0] ra, rb, eq, er;

    n_checks = 0;
    n_pass   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 + 2: basic division and boundary operands.
    vecs[0] = '{16'd100,  16'd7,      16'd14,     16'd2};
    vecs[1] = '{16'hFFFF, 16'h0001,   16'hFFFF,   16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF,   16'h0001,   16'h0000};
    vecs[3] = '{16'h8000, 16'h8001,   16'h0000,   16'h8000};
    vecs[4] = '{16'd1000, 16'd10,     16'd100,    16'd0};
    vecs[5] = '{16'd7,    16'd100,    16'd0,      16'd7};
    vecs[6] = '{16'h1234, 16'h0010,   16'h0123,   16'h0004};
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 17);
    check("idle_after_take", bus.out_valid, 0);

    // 3: zero divisor, held under backpressure.
    bus.out_ready = 1'b0;
    do_accept(16'd1234, 16'd0);
    wait_result(lat);
    check("div0_lat", lat, 1);
    check("div0_q", bus.quotient, 0);
    check("div0_r", bus.remainder, 0);
    for (int i = 0; i < 2; i++) begin
      check("div0_in_ready_low", bus.in_ready, 0);
      @(posedge clk); #1;
      check("div0_held", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("div0_taken", bus.out_valid, 0);

    // 4: backpressure then back-to-back accept from DONE.
    bus.out_ready = 1'b0;
    do_accept(16'd50000, 16'd3);
    wait_result(lat);
    check("bp_lat", lat, 17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_q_held", bus.quotient, 16'd16666);
      check("bp_r_held", bus.remainder, 16'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", bus.in_ready, 1);
    do_accept(16'd9, 16'd2);
    check("b2b_busy", bus.out_valid, 0);
    wait_result(lat);
    check("b2b_lat", lat, 17);
    check("b2b_q", bus.quotient, 16'd4);
    check("b2b_r", bus.remainder, 16'd1);
    @(posedge clk); #1;

    // 5: reset in the middle of an operation.
    do_accept(16'd40000, 16'd9);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check("midrst_q", bus.quotient, 0);
    check("midrst_r", bus.remainder, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);
    run_vec("after_rst", 16'd40000, 16'd9, 16'd4444, 16'd4, 17);

    // 6: pseudo-random pairs plus corner divisors; in_valid pulsed during BUSY.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      case (i % 8)
        0: rb = 16'd0;
        1: rb = 16'd1;
        2: rb = 16'hFFFF;
        3: rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      eq = (rb == 0) ? 16'd0 : ra / rb;
      er = (rb == 0) ? 16'd0 : ra % rb;
      bus.out_ready = 1'b1;
      do_accept(ra, rb);
      if (rb != 0) begin
        for (int k = 0; k < 3; k++) begin
          bus.in_valid = 1'b1;
          bus.dividend = 16'($urandom);
          bus.divisor  = 16'($urandom);
          check("rnd_busy_in_ready", bus.in_ready, 0);
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
      end
      wait_result(lat);
      check("rnd_valid", bus.out_valid, 1);
      check($sformatf("rnd_q_%0h_%0h", ra, rb), bus.quotient, eq);
      check($sformatf("rnd_r_%0h_%0h", ra, rb), bus.remainder, er);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
